// File: rtl/k6502_seq.sv
// 6502 instruction sequencer: owns the instruction register and the one-hot
// cycle counter, injects BRK for NMI/IRQ, and recovers from runaway sequences.
module k6502_seq #(
  parameter logic [7:0]  BRK_OP = 8'h00,
  parameter int unsigned CYC_W  = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rdy,
  input  logic [7:0]       data_in,
  input  logic             sync_next,
  input  logic             i_flag,
  input  logic             nmi_n,
  input  logic             irq_n,
  output logic [7:0]       ir,
  output logic [CYC_W-1:0] cycle,
  output logic [1:0]       int_kind,
  output logic             int_ack,
  output logic             seq_err
);

  typedef enum logic [1:0] {
    KIND_NORMAL = 2'b00,
    KIND_IRQ    = 2'b01,
    KIND_NMI    = 2'b10
  } kind_e;

  localparam logic [CYC_W-1:0] C_0 = CYC_W'(1);

  logic             nmi_s1, nmi_s, nmi_prev, irq_s1, irq_s, nmi_pend;
  logic             nmi_fall, fetch, take_nmi, take_irq, runaway;
  kind_e            kind_q, kind_d;
  logic [7:0]       ir_d;
  logic [CYC_W-1:0] cycle_d;
  logic             ack_d, err_d;

  // Synchronisers and NMI edge detector run independently of rdy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_s1   <= 1'b1;
      nmi_s    <= 1'b1;
      nmi_prev <= 1'b1;
      irq_s1   <= 1'b1;
      irq_s    <= 1'b1;
    end else begin
      nmi_s1   <= nmi_n;
      nmi_s    <= nmi_s1;
      nmi_prev <= nmi_s;
      irq_s1   <= irq_n;
      irq_s    <= irq_s1;
    end
  end

  assign nmi_fall = nmi_prev & ~nmi_s;
  assign fetch    = rdy & sync_next;
  assign take_nmi = fetch & nmi_pend;
  assign take_irq = fetch & ~nmi_pend & ~irq_s & ~i_flag;
  assign runaway  = rdy & ~sync_next & (cycle[CYC_W-1] | (cycle == '0));

  // A new falling edge outranks the clear from a simultaneous NMI take.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      nmi_pend <= 1'b0;
    else if (nmi_fall) nmi_pend <= 1'b1;
    else if (take_nmi) nmi_pend <= 1'b0;
  end

  // Sequencing state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir      <= '0;
      cycle   <= '0;
      kind_q  <= KIND_NORMAL;
      int_ack <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      ir      <= ir_d;
      cycle   <= cycle_d;
      kind_q  <= kind_d;
      int_ack <= ack_d;
      seq_err <= err_d;
    end
  end

  // Next-state decode, first matching rule wins
  always_comb begin
    ir_d    = ir;
    cycle_d = cycle;
    kind_d  = kind_q;
    ack_d   = 1'b0;
    err_d   = seq_err;
    if (!rdy) begin
      ir_d = ir;
    end else if (sync_next) begin
      cycle_d = C_0;
      if (take_nmi) begin
        ir_d   = BRK_OP;
        kind_d = KIND_NMI;
        ack_d  = 1'b1;
      end else if (take_irq) begin
        ir_d   = BRK_OP;
        kind_d = KIND_IRQ;
        ack_d  = 1'b1;
      end else begin
        ir_d   = data_in;
        kind_d = KIND_NORMAL;
      end
    end else if (runaway) begin
      err_d   = 1'b1;
      ir_d    = '0;
      cycle_d = '0;
      kind_d  = KIND_NORMAL;
    end else begin
      cycle_d = cycle << 1;
    end
  end

  assign int_kind = kind_q;

endmodule

// File: tb/tb_k6502_seq.sv
// Bench for k6502_seq: table-driven sequencing vectors plus hand-written
// interrupt, runaway and async-reset sequences, checked through a queue.
module tb_k6502_seq;

  logic       clk = 1'b0;
  logic       reset_n, rdy, sync_next, i_flag, nmi_n, irq_n;
  logic [7:0] data_in;
  logic [7:0] ir;
  logic [5:0] cycle;
  logic [1:0] int_kind;
  logic       int_ack, seq_err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] ir;
    logic [5:0] cyc;
    logic [1:0] kind;
    logic       ack;
    logic       err;
  } exp_t;

  typedef struct {
    logic       rdy;
    logic       sync;
    logic [7:0] data;
    logic       iflag;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];

  k6502_seq #(.BRK_OP(8'h00), .CYC_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .rdy(rdy), .data_in(data_in),
    .sync_next(sync_next), .i_flag(i_flag), .nmi_n(nmi_n), .irq_n(irq_n),
    .ir(ir), .cycle(cycle), .int_kind(int_kind), .int_ack(int_ack),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".ir"},       32'(ir),       32'(e.ir));
    chk({tag, ".cycle"},    32'(cycle),    32'(e.cyc));
    chk({tag, ".int_kind"}, 32'(int_kind), 32'(e.kind));
    chk({tag, ".int_ack"},  32'(int_ack),  32'(e.ack));
    chk({tag, ".seq_err"},  32'(seq_err),  32'(e.err));
  endtask

  // Drive one cycle of inputs, queue the expectation, sample #1 after the edge.
  task automatic step(input string tag, input logic r, input logic s,
                      input logic [7:0] d, input logic f,
                      input logic [7:0] e_ir, input logic [5:0] e_cyc,
                      input logic [1:0] e_kind, input logic e_ack, input logic e_err);
    exp_t e;
    rdy = r; sync_next = s; data_in = d; i_flag = f;
    e.ir = e_ir; e.cyc = e_cyc; e.kind = e_kind; e.ack = e_ack; e.err = e_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s.queue: got empty, expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_outputs(tag, e);
    end
  endtask

  vec_t vecs[13];

  initial begin
    exp_t rst_e;
    rst_e.ir = 8'h00; rst_e.cyc = 6'b0; rst_e.kind = 2'b00; rst_e.ack = 1'b0; rst_e.err = 1'b0;

    vecs[0]  = '{1'b1, 1'b1, 8'hEA, 1'b1, '{8'hEA, 6'b000001, 2'b00, 1'b0, 1'b0}};
    vecs[1]  = '{1'b1, 1'b1, 8'h4C, 1'b1, '{8'h4C, 6'b000001, 2'b00, 1'b0, 1'b0}};
    vecs[2]  = '{1'b1, 1'b0, 8'h11, 1'b1, '{8'h4C, 6'b000010, 2'b00, 1'b0, 1'b0}};
    vecs[3]  = '{1'b1, 1'b0, 8'h22, 1'b1, '{8'h4C, 6'b000100, 2'b00, 1'b0, 1'b0}};
    vecs[4]  = '{1'b1, 1'b1, 8'hA9, 1'b1, '{8'hA9, 6'b000001, 2'b00, 1'b0, 1'b0}};
    vecs[5]  = '{1'b1, 1'b1, 8'h6C, 1'b1, '{8'h6C, 6'b000001, 2'b00, 1'b0, 1'b0}};
    vecs[6]  = '{1'b1, 1'b0, 8'h33, 1'b1, '{8'h6C, 6'b000010, 2'b00, 1'b0, 1'b0}};
    vecs[7]  = '{1'b1, 1'b0, 8'h44, 1'b1, '{8'h6C, 6'b000100, 2'b00, 1'b0, 1'b0}};
    vecs[8]  = '{1'b0, 1'b1, 8'hFF, 1'b0, '{8'h6C, 6'b000100, 2'b00, 1'b0, 1'b0}};
    vecs[9]  = '{1'b0, 1'b0, 8'hFF, 1'b0, '{8'h6C, 6'b000100, 2'b00, 1'b0, 1'b0}};
    vecs[10] = '{1'b0, 1'b1, 8'hFF, 1'b0, '{8'h6C, 6'b000100, 2'b00, 1'b0, 1'b0}};
    vecs[11] = '{1'b1, 1'b0, 8'h55, 1'b1, '{8'h6C, 6'b001000, 2'b00, 1'b0, 1'b0}};
    vecs[12] = '{1'b1, 1'b1, 8'hEA, 1'b1, '{8'hEA, 6'b000001, 2'b00, 1'b0, 1'b0}};

    reset_n = 1'b0; rdy = 1'b1; sync_next = 1'b1; data_in = 8'hEA;
    i_flag = 1'b1; nmi_n = 1'b1; irq_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", rst_e);
    reset_n = 1'b1;

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].sync, vecs[i].data, vecs[i].iflag,
           vecs[i].e.ir, vecs[i].e.cyc, vecs[i].e.kind, vecs[i].e.ack, vecs[i].e.err);

    // NMI: held low, taken exactly once, three edges after first sample
    nmi_n = 1'b0;
    step("nmi_k0", 1, 1, 8'h4C, 1, 8'h4C, 6'b000001, 2'b00, 0, 0);
    step("nmi_k1", 1, 1, 8'h4C, 1, 8'h4C, 6'b000001, 2'b00, 0, 0);
    step("nmi_k2", 1, 1, 8'hAA, 1, 8'hAA, 6'b000001, 2'b00, 0, 0);
    step("nmi_take", 1, 1, 8'hA9, 1, 8'h00, 6'b000001, 2'b10, 1, 0);
    step("nmi_c1", 1, 0, 8'hA9, 1, 8'h00, 6'b000010, 2'b10, 0, 0);
    step("nmi_once", 1, 1, 8'hA9, 1, 8'hA9, 6'b000001, 2'b00, 0, 0);
    nmi_n = 1'b1;

    // IRQ: masked by i_flag, taken when unmasked
    irq_n = 1'b0;
    step("irq_c1", 1, 0, 8'h00, 1, 8'hA9, 6'b000010, 2'b00, 0, 0);
    step("irq_c2", 1, 0, 8'h00, 1, 8'hA9, 6'b000100, 2'b00, 0, 0);
    step("irq_mask", 1, 1, 8'h58, 1, 8'h58, 6'b000001, 2'b00, 0, 0);
    step("irq_take", 1, 1, 8'h58, 0, 8'h00, 6'b000001, 2'b01, 1, 0);
    step("irq_mask2", 1, 1, 8'hEA, 1, 8'hEA, 6'b000001, 2'b00, 0, 0);

    // NMI and IRQ pending together: NMI first, IRQ on the next fetch
    nmi_n = 1'b0;
    step("both_c1", 1, 0, 8'h00, 1, 8'hEA, 6'b000010, 2'b00, 0, 0);
    step("both_c2", 1, 0, 8'h00, 1, 8'hEA, 6'b000100, 2'b00, 0, 0);
    step("both_c3", 1, 0, 8'h00, 1, 8'hEA, 6'b001000, 2'b00, 0, 0);
    step("both_nmi", 1, 1, 8'hEA, 0, 8'h00, 6'b000001, 2'b10, 1, 0);
    step("both_irq", 1, 1, 8'hEA, 0, 8'h00, 6'b000001, 2'b01, 1, 0);
    nmi_n = 1'b1; irq_n = 1'b1;
    step("both_end", 1, 1, 8'hEA, 1, 8'hEA, 6'b000001, 2'b00, 0, 0);

    // Runaway past C_5, sticky seq_err
    for (int unsigned k = 1; k <= 5; k++)
      step($sformatf("run_c%0d", k), 1, 0, 8'h77, 1, 8'hEA, 6'(1 << k), 2'b00, 0, 0);
    step("run_over", 1, 0, 8'h77, 1, 8'h00, 6'b000000, 2'b00, 0, 1);
    step("run_cn", 1, 0, 8'h77, 1, 8'h00, 6'b000000, 2'b00, 0, 1);
    step("run_rdy0", 0, 0, 8'h77, 1, 8'h00, 6'b000000, 2'b00, 0, 1);
    step("run_refetch", 1, 1, 8'hEA, 1, 8'hEA, 6'b000001, 2'b00, 0, 1);
    step("run_c1b", 1, 0, 8'hEA, 1, 8'hEA, 6'b000010, 2'b00, 0, 1);

    // Async reset mid-cycle, no clock edge in between
    #3;
    reset_n = 1'b0;
    #1;
    check_outputs("async_rst", rst_e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
